dual_issue_ctl: RTL and testbench
=================================

// Module: dual_issue_ctl
// PURPOSE
//  Issue stage directly upstream of the dual-ported register file. Accepts an aligned
//  instruction pair {A,B} from fetch and checks intra-pair hazards. Issues both slots
//  or splits the pair. Drives the four register-file read addresses and the two
//  write-back destinations/enables that travel down the pipe.
// PARAMETERS
//  XLEN       32  instruction / PC width
//  REG_AW     5   register address width
//  PC_STEP    4   byte offset of slot B from slot A (pcB = pcA + PC_STEP)
//  MEM_PORTS  1   data-memory ports; 1 => two memory ops in one pair are split
// PORTS
//  clk            in   1       clock, all state on posedge
//  rst_n          in   1       asynchronous, active-low reset
//  flush          in   1       synchronous squash (branch redirect), highest priority
//  fetch_valid    in   1       fetch pair valid
//  fetch_ready    out  1       pair accepted when fetch_valid & fetch_ready
//  fetch_pc       in   XLEN    PC of slot A
//  fetch_instA    in   XLEN    older instruction
//  fetch_instB    in   XLEN    younger instruction
//  id_ready       in   1       downstream consumes current bundle this cycle
//  issue_validA/B out  1       slot valid
//  issue_instA/B  out  XLEN    issued instructions
//  issue_pcA/B    out  XLEN    issued PCs
//  readA1/A2      out  REG_AW  rs/rt of slot A (0 when unused or invalid)
//  readB1/B2      out  REG_AW  rs/rt of slot B (0 when unused or invalid)
//  wrregA/B       out  REG_AW  destination register; 0 when none
//  regwriteA/B    out  1       slot writes a non-zero register
//  stat_pairs     out  32      pairs issued together (see CONFIGURATION)
//  stat_splits    out  32      pairs split
// BEHAVIOUR
//  Reset: state IDLE; every output 0, including fetch_ready=0 while rst_n low.
//  Outputs are registered. A pair accepted at edge N appears on issue_* after edge N.
//  Decode: R-type (op 0) dst=rd and srcs rs,rt. ALU-imm/loads dst=rt and src rs.
//   Stores/beq/bne have srcs rs,rt and no dst. jal dst=31. j has no dst or srcs.
//   lui dst=rt with no src.
//  Split when any of these hold:
//   A has dst!=0 that equals a src of B (RAW).
//   dstA==dstB!=0 (WAW).
//   Both are loads/stores and MEM_PORTS==1.
//   B is a branch or jump.
//  A branch in slot A pairs normally; B is its delay slot.
//  States:
//   IDLE: fetch_ready=1. On a fetch handshake, load the pair and go to ISSUE
//    (both valid) or SPLIT (only A valid, B held internally).
//   ISSUE: fetch_ready=id_ready.
//    If id_ready and fetch_valid, load the next pair the same cycle and go to
//    ISSUE or SPLIT.
//    If id_ready and no fetch_valid, go to IDLE.
//    If !id_ready, hold all outputs.
//   SPLIT: fetch_ready=0. On id_ready, the held B moves into slot A
//    (issue_pcA = old pcB), issue_validB=0, and state goes to ISSUE.
//  Outputs are stable while issue_valid* is high and id_ready is low (no bubbles, no drops).
//  flush: next state IDLE, valids cleared, held B discarded, fetch_ready=0 that cycle.
//   flush overrides a simultaneous fetch handshake.
//  Reset mid-operation discards everything; no partial bundle survives.
//  Register 0 is never reported as a dependency.
// CONFIGURATION
//  DUAL_ISSUE_STATS_EN defined:
//   stat_pairs/stat_splits count on bundle load.
//   Both clear on reset and saturate at 32'hFFFF_FFFF.
//  Not defined: counters are absent and both ports are tied to 32'd0.
// STRUCTURE
//  Include dual_issue_defs.vh: opcode/funct localparams, state encoding
//   (IDLE/ISSUE/SPLIT), split-reason codes.
//  Sub-module mips_reg_decode (combinational), instantiated twice. It maps an
//   instruction to src1, src2, dst, is_mem and is_ctrl.
// TESTING
//  Pair add $8,$9,$10 / sub $11,$12,$13, id_ready=1:
//   both valid next cycle; readB1=12, wrregA=8, wrregB=11.
//  RAW: add $8,$9,$10 / or $11,$8,$2:
//   cycle1 A only; cycle2 slotA=or with pcA=pc+4, validB=0; fetch_ready=0 during SPLIT.
//  Two loads lw $8,0($4) / lw $9,4($4), MEM_PORTS=1: split.
//   Pair beq $1,$2 / addi $3,$3,1: issued together.
//  id_ready=0 for 3 cycles with a valid bundle:
//   outputs unchanged, fetch_ready=0, no pair lost.
//  flush asserted during SPLIT with fetch_valid=1:
//   next cycle IDLE, all valids 0, held B never issued.
//  rst_n low mid-stream: all outputs 0 immediately.
//   With DUAL_ISSUE_STATS_EN, counters read 0 after reset.

Source files
------------

// File: rtl/dual_issue_ctl_pkg.sv
// Shared definitions for the dual-issue controller: MIPS opcode/funct values,
// controller state encoding and the reasons a fetched pair may be split.
package dual_issue_ctl_pkg;

    // Primary opcodes (inst[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes that change control flow
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    // Link register written by jal
    localparam int REG_RA = 31;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_SPLIT = 2'd2
    } state_t;

    // Why a pair could not issue together (first matching reason wins)
    typedef enum logic [2:0] {
        SPLIT_NONE = 3'd0,
        SPLIT_RAW  = 3'd1,
        SPLIT_WAW  = 3'd2,
        SPLIT_MEM  = 3'd3,
        SPLIT_CTRL = 3'd4
    } split_reason_t;

endpackage

// File: rtl/dual_issue_ctl_decode.sv
// mips_reg_decode: purely combinational register-usage decode of one MIPS
// instruction. Unused sources/destinations are reported as register 0.
module mips_reg_decode
    import dual_issue_ctl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic [XLEN-1:0]   inst,
    output logic [REG_AW-1:0] src1,
    output logic [REG_AW-1:0] src2,
    output logic [REG_AW-1:0] dst,
    output logic              is_mem,
    output logic              is_ctrl
);

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [4:0]        shamt_unused;

    assign op           = inst[31:26];
    assign funct        = inst[5:0];
    assign rs           = REG_AW'(inst[25:21]);
    assign rt           = REG_AW'(inst[20:16]);
    assign rd           = REG_AW'(inst[15:11]);
    assign shamt_unused = inst[10:6];

    // Map the opcode class to the registers it reads and writes
    always_comb begin
        src1    = '0;
        src2    = '0;
        dst     = '0;
        is_mem  = 1'b0;
        is_ctrl = 1'b0;
        case (op)
            OP_RTYPE: begin
                if (funct == FN_JR) begin
                    src1    = rs;
                    is_ctrl = 1'b1;
                end else if (funct == FN_JALR) begin
                    src1    = rs;
                    dst     = rd;
                    is_ctrl = 1'b1;
                end else begin
                    src1 = rs;
                    src2 = rt;
                    dst  = rd;
                end
            end
            OP_J: begin
                is_ctrl = 1'b1;
            end
            OP_JAL: begin
                dst     = REG_AW'(REG_RA);
                is_ctrl = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                src1    = rs;
                src2    = rt;
                is_ctrl = 1'b1;
            end
            OP_BLEZ, OP_BGTZ: begin
                src1    = rs;
                is_ctrl = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                src1 = rs;
                dst  = rt;
            end
            OP_LUI: begin
                dst = rt;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                src1   = rs;
                dst    = rt;
                is_mem = 1'b1;
            end
            OP_SB, OP_SH, OP_SW: begin
                src1   = rs;
                src2   = rt;
                is_mem = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/dual_issue_ctl.sv
// dual_issue_ctl: issue stage in front of the dual-ported register file.
// Takes an aligned {A,B} pair from fetch, issues both slots together or splits
// the pair on an intra-pair hazard, and drives registered read addresses and
// write-back destinations for both slots.
// Optional statistics counters are built when DUAL_ISSUE_STATS_EN is defined.
module dual_issue_ctl
    import dual_issue_ctl_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int PC_STEP   = 4,
    parameter int MEM_PORTS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              fetch_valid,
    output logic              fetch_ready,
    input  logic [XLEN-1:0]   fetch_pc,
    input  logic [XLEN-1:0]   fetch_instA,
    input  logic [XLEN-1:0]   fetch_instB,
    input  logic              id_ready,
    output logic              issue_validA,
    output logic              issue_validB,
    output logic [XLEN-1:0]   issue_instA,
    output logic [XLEN-1:0]   issue_instB,
    output logic [XLEN-1:0]   issue_pcA,
    output logic [XLEN-1:0]   issue_pcB,
    output logic [REG_AW-1:0] readA1,
    output logic [REG_AW-1:0] readA2,
    output logic [REG_AW-1:0] readB1,
    output logic [REG_AW-1:0] readB2,
    output logic [REG_AW-1:0] wrregA,
    output logic [REG_AW-1:0] wrregB,
    output logic              regwriteA,
    output logic              regwriteB,
    output logic [31:0]       stat_pairs,
    output logic [31:0]       stat_splits
);

    // One issue slot as it travels down the pipe; an empty slot is all zero
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   inst;
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
        logic [REG_AW-1:0] dst;
        logic              wr;
    } slot_t;

    function automatic slot_t make_slot(input logic [XLEN-1:0]   inst,
                                        input logic [XLEN-1:0]   pc,
                                        input logic [REG_AW-1:0] s1,
                                        input logic [REG_AW-1:0] s2,
                                        input logic [REG_AW-1:0] d);
        slot_t s;
        s.valid = 1'b1;
        s.inst  = inst;
        s.pc    = pc;
        s.src1  = s1;
        s.src2  = s2;
        s.dst   = d;
        s.wr    = (d != '0);
        return s;
    endfunction

    state_t        state;
    logic          ready_en;
    slot_t         slot_a;
    slot_t         slot_b;
    slot_t         held_b;
    slot_t         new_a;
    slot_t         new_b;
    split_reason_t split_reason;
    logic          is_split;
    logic          load_fire;
    logic [XLEN-1:0]   pc_b;

    logic [REG_AW-1:0] a_src1, a_src2, a_dst;
    logic [REG_AW-1:0] b_src1, b_src2, b_dst;
    logic              a_mem, b_mem, b_ctrl;
    logic              a_ctrl_unused;

    mips_reg_decode #(.XLEN(XLEN), .REG_AW(REG_AW)) u_dec_a (
        .inst    (fetch_instA),
        .src1    (a_src1),
        .src2    (a_src2),
        .dst     (a_dst),
        .is_mem  (a_mem),
        .is_ctrl (a_ctrl_unused)
    );

    mips_reg_decode #(.XLEN(XLEN), .REG_AW(REG_AW)) u_dec_b (
        .inst    (fetch_instB),
        .src1    (b_src1),
        .src2    (b_src2),
        .dst     (b_dst),
        .is_mem  (b_mem),
        .is_ctrl (b_ctrl)
    );

    assign pc_b  = fetch_pc + XLEN'(PC_STEP);
    assign new_a = make_slot(fetch_instA, fetch_pc, a_src1, a_src2, a_dst);
    assign new_b = make_slot(fetch_instB, pc_b, b_src1, b_src2, b_dst);

    // Classify intra-pair hazards; register 0 never creates a dependency
    always_comb begin
        split_reason = SPLIT_NONE;
        if ((a_dst != '0) && ((a_dst == b_src1) || (a_dst == b_src2))) begin
            split_reason = SPLIT_RAW;
        end else if ((a_dst != '0) && (a_dst == b_dst)) begin
            split_reason = SPLIT_WAW;
        end else if ((MEM_PORTS == 1) && a_mem && b_mem) begin
            split_reason = SPLIT_MEM;
        end else if (b_ctrl) begin
            split_reason = SPLIT_CTRL;
        end
    end

    assign is_split = (split_reason != SPLIT_NONE);

    // Ready only once out of reset, never during flush, and in ISSUE only when the current bundle drains
    assign fetch_ready = ready_en && !flush &&
                         ((state == ST_IDLE) || ((state == ST_ISSUE) && id_ready));
    assign load_fire   = fetch_valid && fetch_ready;

    // Controller FSM: loads pairs, replays a held slot B, and squashes on flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ready_en <= 1'b0;
            slot_a   <= '0;
            slot_b   <= '0;
            held_b   <= '0;
        end else begin
            ready_en <= 1'b1;
            if (flush) begin
                state  <= ST_IDLE;
                slot_a <= '0;
                slot_b <= '0;
                held_b <= '0;
            end else if (load_fire) begin
                slot_a <= new_a;
                if (is_split) begin
                    slot_b <= '0;
                    held_b <= new_b;
                    state  <= ST_SPLIT;
                end else begin
                    slot_b <= new_b;
                    held_b <= '0;
                    state  <= ST_ISSUE;
                end
            end else begin
                case (state)
                    ST_ISSUE: begin
                        if (id_ready) begin
                            slot_a <= '0;
                            slot_b <= '0;
                            state  <= ST_IDLE;
                        end
                    end
                    ST_SPLIT: begin
                        if (id_ready) begin
                            slot_a <= held_b;
                            slot_b <= '0;
                            held_b <= '0;
                            state  <= ST_ISSUE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign issue_validA = slot_a.valid;
    assign issue_validB = slot_b.valid;
    assign issue_instA  = slot_a.inst;
    assign issue_instB  = slot_b.inst;
    assign issue_pcA    = slot_a.pc;
    assign issue_pcB    = slot_b.pc;
    assign readA1       = slot_a.src1;
    assign readA2       = slot_a.src2;
    assign readB1       = slot_b.src1;
    assign readB2       = slot_b.src2;
    assign wrregA       = slot_a.dst;
    assign wrregB       = slot_b.dst;
    assign regwriteA    = slot_a.wr;
    assign regwriteB    = slot_b.wr;

`ifdef DUAL_ISSUE_STATS_EN
    logic [31:0] pair_cnt;
    logic [31:0] split_cnt;

    // Saturating counts of pairs issued together versus split, taken at bundle load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_cnt  <= 32'd0;
            split_cnt <= 32'd0;
        end else if (load_fire) begin
            if (is_split) begin
                if (split_cnt != 32'hFFFF_FFFF) split_cnt <= split_cnt + 32'd1;
            end else begin
                if (pair_cnt != 32'hFFFF_FFFF) pair_cnt <= pair_cnt + 32'd1;
            end
        end
    end

    assign stat_pairs  = pair_cnt;
    assign stat_splits = split_cnt;
`else
    assign stat_pairs  = 32'd0;
    assign stat_splits = 32'd0;
`endif

endmodule

// File: tb/tb_dual_issue_ctl.sv
// Directed testbench for dual_issue_ctl: pairing, RAW/WAW/memory splits,
// stall hold, flush during SPLIT and asynchronous reset mid-stream.
// Expected statistics depend on DUAL_ISSUE_STATS_EN.
module tb_dual_issue_ctl;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instA;
    logic [31:0] fetch_instB;
    logic        id_ready;
    logic        issue_validA, issue_validB;
    logic [31:0] issue_instA, issue_instB;
    logic [31:0] issue_pcA, issue_pcB;
    logic [4:0]  readA1, readA2, readB1, readB2;
    logic [4:0]  wrregA, wrregB;
    logic        regwriteA, regwriteB;
    logic [31:0] stat_pairs, stat_splits;

    int total = 0;
    int bad   = 0;

`ifdef DUAL_ISSUE_STATS_EN
    localparam logic [31:0] EXP_PAIRS  = 32'd4;
    localparam logic [31:0] EXP_SPLITS = 32'd4;
`else
    localparam logic [31:0] EXP_PAIRS  = 32'd0;
    localparam logic [31:0] EXP_SPLITS = 32'd0;
`endif

    dual_issue_ctl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .fetch_pc     (fetch_pc),
        .fetch_instA  (fetch_instA),
        .fetch_instB  (fetch_instB),
        .id_ready     (id_ready),
        .issue_validA (issue_validA),
        .issue_validB (issue_validB),
        .issue_instA  (issue_instA),
        .issue_instB  (issue_instB),
        .issue_pcA    (issue_pcA),
        .issue_pcB    (issue_pcB),
        .readA1       (readA1),
        .readA2       (readA2),
        .readB1       (readB1),
        .readB2       (readB2),
        .wrregA       (wrregA),
        .wrregB       (wrregB),
        .regwriteA    (regwriteA),
        .regwriteB    (regwriteB),
        .stat_pairs   (stat_pairs),
        .stat_splits  (stat_splits)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    // Drive all fetch-side inputs, then let combinational ready settle
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] ia,
                                 input logic [31:0] ib, input logic idr, input logic fl);
        fetch_valid = v;
        fetch_pc    = pc;
        fetch_instA = ia;
        fetch_instB = ib;
        id_ready    = idr;
        flush       = fl;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are then sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [31:0] i_add, i_sub, i_or, i_lw1, i_lw2, i_beq, i_addi, i_w1, i_w2;

    initial begin
        i_add  = rtype(9, 10, 8, 6'h20);
        i_sub  = rtype(12, 13, 11, 6'h22);
        i_or   = rtype(8, 2, 11, 6'h25);
        i_lw1  = itype(6'h23, 4, 8, 16'd0);
        i_lw2  = itype(6'h23, 4, 9, 16'd4);
        i_beq  = itype(6'h04, 1, 2, 16'd3);
        i_addi = itype(6'h08, 3, 3, 16'd1);
        i_w1   = itype(6'h08, 1, 5, 16'd1);
        i_w2   = itype(6'h08, 2, 5, 16'd2);

        $display("[TB] start");
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("rst_validA", 32'(issue_validA), 32'd0);
        checkOutput("rst_ready",  32'(fetch_ready),  32'd0);
        checkOutput("rst_instA",  issue_instA,       32'd0);
        checkOutput("rst_pairs",  stat_pairs,        32'd0);

        rst_n = 1'b1;
        tick();
        checkOutput("idle_ready", 32'(fetch_ready), 32'd1);

        // Independent pair issues together
        applyStimulus(1'b1, 32'h100, i_add, i_sub, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("pair_validA", 32'(issue_validA), 32'd1);
        checkOutput("pair_validB", 32'(issue_validB), 32'd1);
        checkOutput("pair_pcB",    issue_pcB,         32'h104);
        checkOutput("pair_readA1", 32'(readA1),       32'd9);
        checkOutput("pair_readB1", 32'(readB1),       32'd12);
        checkOutput("pair_readB2", 32'(readB2),       32'd13);
        checkOutput("pair_wrregA", 32'(wrregA),       32'd8);
        checkOutput("pair_wrregB", 32'(wrregB),       32'd11);
        checkOutput("issue_ready", 32'(fetch_ready),  32'd1);
        tick();
        checkOutput("drain_validA", 32'(issue_validA), 32'd0);

        // RAW split: or reads $8 written by add
        applyStimulus(1'b1, 32'h200, i_add, i_or, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("raw1_instA",  issue_instA,       i_add);
        checkOutput("raw1_validB", 32'(issue_validB), 32'd0);
        checkOutput("raw1_readB1", 32'(readB1),       32'd0);
        checkOutput("split_ready", 32'(fetch_ready),  32'd0);
        tick();
        checkOutput("raw2_instA",  issue_instA,       i_or);
        checkOutput("raw2_pcA",    issue_pcA,         32'h204);
        checkOutput("raw2_validB", 32'(issue_validB), 32'd0);
        checkOutput("raw2_readA1", 32'(readA1),       32'd8);
        checkOutput("raw2_wrregA", 32'(wrregA),       32'd11);
        tick();

        // WAW split: both addi write $5
        applyStimulus(1'b1, 32'h280, i_w1, i_w2, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("waw1_validB", 32'(issue_validB), 32'd0);
        checkOutput("waw1_wrregA", 32'(wrregA),       32'd5);
        tick();
        checkOutput("waw2_pcA",    issue_pcA,         32'h284);
        checkOutput("waw2_readA1", 32'(readA1),       32'd2);
        tick();

        // Two loads share the single memory port
        applyStimulus(1'b1, 32'h300, i_lw1, i_lw2, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("lw1_validB", 32'(issue_validB), 32'd0);
        checkOutput("lw1_readA1", 32'(readA1),       32'd4);
        checkOutput("lw1_readA2", 32'(readA2),       32'd0);
        checkOutput("lw1_wrregA", 32'(wrregA),       32'd8);
        tick();
        checkOutput("lw2_instA",  issue_instA,       i_lw2);
        checkOutput("lw2_wrregA", 32'(wrregA),       32'd9);

        // Branch in slot A pairs with its delay slot, loaded back-to-back
        applyStimulus(1'b1, 32'h400, i_beq, i_addi, 1'b1, 1'b0);
        checkOutput("b2b_ready", 32'(fetch_ready), 32'd1);
        tick();
        checkOutput("beq_validB",    32'(issue_validB), 32'd1);
        checkOutput("beq_readA2",    32'(readA2),       32'd2);
        checkOutput("beq_regwriteA", 32'(regwriteA),    32'd0);
        checkOutput("beq_wrregB",    32'(wrregB),       32'd3);
        checkOutput("beq_regwriteB", 32'(regwriteB),    32'd1);

        // Stall three cycles with the next pair waiting
        applyStimulus(1'b1, 32'h500, i_sub, i_add, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checkOutput("stall_ready", 32'(fetch_ready), 32'd0);
            tick();
            checkOutput("stall_instA", issue_instA,       i_beq);
            checkOutput("stall_pcB",   issue_pcB,         32'h404);
            checkOutput("stall_validB", 32'(issue_validB), 32'd1);
        end
        applyStimulus(1'b1, 32'h500, i_sub, i_add, 1'b1, 1'b0);
        tick();
        checkOutput("post_stall_instA", issue_instA, i_sub);
        checkOutput("post_stall_instB", issue_instB, i_add);
        checkOutput("post_stall_pcA",   issue_pcA,   32'h500);

        // Flush while a split B is held, with fetch offering another pair
        applyStimulus(1'b1, 32'h600, i_add, i_or, 1'b1, 1'b0);
        tick();
        checkOutput("fl_split_instA", issue_instA, i_add);
        applyStimulus(1'b1, 32'h700, i_sub, i_add, 1'b1, 1'b1);
        checkOutput("flush_ready", 32'(fetch_ready), 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("flush_validA", 32'(issue_validA), 32'd0);
        checkOutput("flush_validB", 32'(issue_validB), 32'd0);
        checkOutput("flush_idle_ready", 32'(fetch_ready), 32'd1);
        tick();
        checkOutput("flush_noB_validA", 32'(issue_validA), 32'd0);

        // Asynchronous reset in the middle of an issued bundle
        applyStimulus(1'b1, 32'h800, i_add, i_sub, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("pre_rst_validA", 32'(issue_validA), 32'd1);
        checkOutput("stat_pairs",     stat_pairs,        EXP_PAIRS);
        checkOutput("stat_splits",    stat_splits,       EXP_SPLITS);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_validA",    32'(issue_validA), 32'd0);
        checkOutput("mid_rst_validB",    32'(issue_validB), 32'd0);
        checkOutput("mid_rst_regwriteB", 32'(regwriteB),    32'd0);
        checkOutput("mid_rst_ready",     32'(fetch_ready),  32'd0);
        checkOutput("mid_rst_pairs",     stat_pairs,        32'd0);
        checkOutput("mid_rst_splits",    stat_splits,       32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_ready",  32'(fetch_ready),  32'd1);
        checkOutput("post_rst_validA", 32'(issue_validA), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
